// File: rtl/cpu_pkg.sv
// Shared CPU types for the register-file write path: destination selector
// encoding, special register indices and the queued write-back entry layout.
package cpu_pkg;

   typedef logic [4:0] reg_idx_t;

   typedef enum logic [1:0] {
      RD   = 2'b00,
      RT   = 2'b01,
      LINK = 2'b10,
      XP   = 2'b11
   } regdst_t;

   localparam reg_idx_t LINK_REG = 5'd31;
   localparam reg_idx_t XP_REG   = 5'd1;

   typedef struct packed {
      reg_idx_t    idx;
      logic [31:0] data;
   } wb_entry_t;

   // Index 0 coming out of here means the write is discarded by the caller.
   function automatic reg_idx_t resolve_dst(input regdst_t dst, input reg_idx_t idx,
                                            input reg_idx_t link_idx, input reg_idx_t xp_idx);
      case (dst)
         LINK:    return link_idx;
         XP:      return xp_idx;
         default: return idx;
      endcase
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency write-back entries until the
// write port is free. DEPTH must be a power of two so the pointers wrap for free.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/regfile_writer.sv
// Sole write-port initiator for the register file: ALU results win, queued
// long-latency results fill idle cycles, and a pending scoreboard feeds decode.
// Optional REGFILE_WRITER_FWD_EN adds a bypass of the not-yet-committed write.
module regfile_writer #(
   parameter int         DEPTH    = 2,
   parameter logic [4:0] LINK_REG = cpu_pkg::LINK_REG,
   parameter logic [4:0] XP_REG   = cpu_pkg::XP_REG
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [1:0]  alu_regdst,
   input  logic [4:0]  alu_reg,
   input  logic [31:0] alu_data,
   input  logic        ll_issue,
   input  logic [4:0]  ll_issue_reg,
   input  logic        ll_valid,
   output logic        ll_ready,
   input  logic [4:0]  ll_reg,
   input  logic [31:0] ll_data,
   input  logic [4:0]  chk_ra,
   input  logic [4:0]  chk_rb,
   output logic        hazard,
   output logic        waw_err,
   output logic        RegWrite,
   output logic [1:0]  RegDst,
   output logic [4:0]  wreg,
   output logic [31:0] wdata
`ifdef REGFILE_WRITER_FWD_EN
   ,
   output logic        fwd_a_hit,
   output logic        fwd_b_hit,
   output logic [31:0] fwd_data
`endif
);

   import cpu_pkg::*;

   wb_entry_t   head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;
   reg_idx_t    alu_dst;

   logic        regwrite_q, regwrite_d;
   reg_idx_t    wreg_q, wreg_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] pending_q, pending_d;
   logic        waw_q, waw_d;

   assign alu_dst   = resolve_dst(regdst_t'(alu_regdst), alu_reg, LINK_REG, XP_REG);
   assign fifo_push = ll_valid && !fifo_full;
   assign fifo_pop  = !alu_valid && !fifo_empty;

   wb_fifo #(
      .DEPTH(DEPTH),
      .WIDTH($bits(wb_entry_t))
   ) u_wb_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({ll_reg, ll_data}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A destination of r0 still consumes its slot but never raises RegWrite.
   always_comb begin
      regwrite_d = 1'b0;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      if (alu_valid) begin
         if (alu_dst != '0) begin
            regwrite_d = 1'b1;
            wreg_d     = alu_dst;
            wdata_d    = alu_data;
         end
      end else if (fifo_pop) begin
         if (head.idx != '0) begin
            regwrite_d = 1'b1;
            wreg_d     = head.idx;
            wdata_d    = head.data;
         end
      end
   end

   // Clear before set so a new claim issued in the same cycle survives.
   always_comb begin
      pending_d = pending_q;
      if (fifo_pop) begin
         pending_d[head.idx] = 1'b0;
      end
      if (ll_issue && (ll_issue_reg != '0)) begin
         pending_d[ll_issue_reg] = 1'b1;
      end
      pending_d[0] = 1'b0;
      waw_d = waw_q || (alu_valid && (alu_dst != '0) && pending_q[alu_dst]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
         pending_q  <= '0;
         waw_q      <= 1'b0;
      end else begin
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
         pending_q  <= pending_d;
         waw_q      <= waw_d;
      end
   end

   assign ll_ready = !fifo_full;
   assign hazard   = pending_q[chk_ra] || pending_q[chk_rb];
   assign waw_err  = waw_q;
   assign RegWrite = regwrite_q;
   assign RegDst   = RD;
   assign wreg     = wreg_q;
   assign wdata    = wdata_q;

`ifdef REGFILE_WRITER_FWD_EN
   assign fwd_a_hit = regwrite_q && (wreg_q == chk_ra) && (chk_ra != '0);
   assign fwd_b_hit = regwrite_q && (wreg_q == chk_rb) && (chk_rb != '0);
   assign fwd_data  = wdata_q;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: table-driven ALU vectors plus
// hand-written long-latency, queue-full, WAW and mid-operation reset sequences.
module tb_regfile_writer;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [1:0]  alu_regdst;
   logic [4:0]  alu_reg;
   logic [31:0] alu_data;
   logic        ll_issue;
   logic [4:0]  ll_issue_reg;
   logic        ll_valid;
   logic        ll_ready;
   logic [4:0]  ll_reg;
   logic [31:0] ll_data;
   logic [4:0]  chk_ra;
   logic [4:0]  chk_rb;
   logic        hazard;
   logic        waw_err;
   logic        RegWrite;
   logic [1:0]  RegDst;
   logic [4:0]  wreg;
   logic [31:0] wdata;
`ifdef REGFILE_WRITER_FWD_EN
   logic        fwd_a_hit;
   logic        fwd_b_hit;
   logic [31:0] fwd_data;
`endif

   regfile_writer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_regdst   (alu_regdst),
      .alu_reg      (alu_reg),
      .alu_data     (alu_data),
      .ll_issue     (ll_issue),
      .ll_issue_reg (ll_issue_reg),
      .ll_valid     (ll_valid),
      .ll_ready     (ll_ready),
      .ll_reg       (ll_reg),
      .ll_data      (ll_data),
      .chk_ra       (chk_ra),
      .chk_rb       (chk_rb),
      .hazard       (hazard),
      .waw_err      (waw_err),
      .RegWrite     (RegWrite),
      .RegDst       (RegDst),
      .wreg         (wreg),
      .wdata        (wdata)
`ifdef REGFILE_WRITER_FWD_EN
      ,
      .fwd_a_hit    (fwd_a_hit),
      .fwd_b_hit    (fwd_b_hit),
      .fwd_data     (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  idx;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } ll_t;

   typedef struct {
      logic        av;
      logic [1:0]  rd;
      logic [4:0]  r;
      logic [31:0] d;
      exp_t        e;
   } vec_t;

   exp_t        exp_q[$];
   ll_t         llq[$];
   logic [31:0] pending_m;
   logic        waw_m;
   exp_t        no_exp;
   vec_t        vecs[8];
   int          n_compared;
   int          n_mismatch;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [4:0] benchDst(input logic [1:0] rd, input logic [4:0] r);
      if (rd == 2'b10) return 5'd31;
      if (rd == 2'b11) return 5'd1;
      return r;
   endfunction

   // Called at a negedge with inputs already driven; predicts the coming edge.
   task automatic applyStimulus(input bit from_table, input exp_t tbl, output bit accepted);
      exp_t       e;
      bit         ready_m;
      logic [4:0] d;
      ready_m = (llq.size() < DEPTH);
      checkVal("ll_ready", 32'(ll_ready), 32'(ready_m));
      e = '{1'b0, 5'd0, 32'd0};
      if (alu_valid) begin
         d = benchDst(alu_regdst, alu_reg);
         if (d != 5'd0) begin
            e = '{1'b1, d, alu_data};
            if (pending_m[d]) waw_m = 1'b1;
         end
      end else if (llq.size() > 0) begin
         ll_t h;
         h = llq.pop_front();
         pending_m[h.idx] = 1'b0;
         if (h.idx != 5'd0) e = '{1'b1, h.idx, h.data};
      end
      if (ll_valid && ready_m) llq.push_back('{ll_reg, ll_data});
      if (ll_issue && (ll_issue_reg != 5'd0)) pending_m[ll_issue_reg] = 1'b1;
      pending_m[0] = 1'b0;
      if (from_table) e = tbl;
      exp_q.push_back(e);
      accepted = ll_valid && ready_m;
   endtask

   task automatic checkOutput();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_compared++;
         n_mismatch++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e = exp_q.pop_front();
      checkVal("RegWrite", 32'(RegWrite), 32'(e.we));
      if (e.we) begin
         checkVal("wreg", 32'(wreg), 32'(e.idx));
         checkVal("wdata", wdata, e.data);
      end
      checkVal("hazard", 32'(hazard), 32'(pending_m[chk_ra] | pending_m[chk_rb]));
      checkVal("waw_err", 32'(waw_err), 32'(waw_m));
      checkVal("RegDst", 32'(RegDst), 32'd0);
`ifdef REGFILE_WRITER_FWD_EN
      checkVal("fwd_a_hit", 32'(fwd_a_hit), 32'(e.we && (e.idx == chk_ra) && (chk_ra != 5'd0)));
      checkVal("fwd_b_hit", 32'(fwd_b_hit), 32'(e.we && (e.idx == chk_rb) && (chk_rb != 5'd0)));
      if (e.we) checkVal("fwd_data", fwd_data, e.data);
`endif
   endtask

   task automatic step(input bit from_table, input exp_t tbl, output bit accepted);
      applyStimulus(from_table, tbl, accepted);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      bit acc;
      alu_valid = 1'b0;
      ll_issue  = 1'b0;
      ll_valid  = 1'b0;
      for (int i = 0; i < n; i++) step(1'b0, no_exp, acc);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc;
      int pushed;
      n_compared   = 0;
      n_mismatch   = 0;
      pending_m    = '0;
      waw_m        = 1'b0;
      no_exp       = '{1'b0, 5'd0, 32'd0};
      reset        = 1'b1;
      alu_valid    = 1'b0;
      alu_regdst   = 2'b00;
      alu_reg      = 5'd0;
      alu_data     = 32'd0;
      ll_issue     = 1'b0;
      ll_issue_reg = 5'd0;
      ll_valid     = 1'b0;
      ll_reg       = 5'd0;
      ll_data      = 32'd0;
      chk_ra       = 5'd0;
      chk_rb       = 5'd0;

      vecs[0] = '{1'b1, 2'b00, 5'd5,  32'hDEADBEEF, '{1'b1, 5'd5,  32'hDEADBEEF}};
      vecs[1] = '{1'b0, 2'b00, 5'd5,  32'h00000000, '{1'b0, 5'd0,  32'h00000000}};
      vecs[2] = '{1'b1, 2'b10, 5'd9,  32'h0000AAAA, '{1'b1, 5'd31, 32'h0000AAAA}};
      vecs[3] = '{1'b1, 2'b11, 5'd9,  32'h0000BBBB, '{1'b1, 5'd1,  32'h0000BBBB}};
      vecs[4] = '{1'b1, 2'b00, 5'd0,  32'h0000CCCC, '{1'b0, 5'd0,  32'h00000000}};
      vecs[5] = '{1'b1, 2'b01, 5'd12, 32'h11112222, '{1'b1, 5'd12, 32'h11112222}};
      vecs[6] = '{1'b1, 2'b10, 5'd0,  32'h33334444, '{1'b1, 5'd31, 32'h33334444}};
      vecs[7] = '{1'b0, 2'b01, 5'd3,  32'h55556666, '{1'b0, 5'd0,  32'h00000000}};

      @(negedge clk);
      @(negedge clk);
      checkVal("reset RegWrite", 32'(RegWrite), 32'd0);
      checkVal("reset RegDst", 32'(RegDst), 32'd0);
      checkVal("reset wreg", 32'(wreg), 32'd0);
      checkVal("reset wdata", wdata, 32'd0);
      checkVal("reset ll_ready", 32'(ll_ready), 32'd1);
      checkVal("reset hazard", 32'(hazard), 32'd0);
      checkVal("reset waw_err", 32'(waw_err), 32'd0);
      reset = 1'b0;

      $display("[TB] ALU destination table");
      for (int i = 0; i < 8; i++) begin
         alu_valid  = vecs[i].av;
         alu_regdst = vecs[i].rd;
         alu_reg    = vecs[i].r;
         alu_data   = vecs[i].d;
         step(1'b1, vecs[i].e, acc);
      end

      $display("[TB] long-latency result with hazard");
      idle(1);
      chk_ra       = 5'd7;
      ll_issue     = 1'b1;
      ll_issue_reg = 5'd7;
      step(1'b0, no_exp, acc);
      ll_issue = 1'b0;
      idle(2);
      checkVal("hazard r7 pending", 32'(hazard), 32'd1);
      ll_valid = 1'b1;
      ll_reg   = 5'd7;
      ll_data  = 32'h00001234;
      step(1'b0, no_exp, acc);
      ll_valid = 1'b0;
      step(1'b0, no_exp, acc);
      checkVal("r7 write wreg", 32'(wreg), 32'd7);
      checkVal("hazard r7 cleared", 32'(hazard), 32'd0);
      idle(1);

      $display("[TB] queue fill under ALU pressure");
      chk_ra = 5'd10;
      chk_rb = 5'd12;
      for (int i = 0; i < 3; i++) begin
         ll_issue     = 1'b1;
         ll_issue_reg = 5'(10 + i);
         step(1'b0, no_exp, acc);
      end
      ll_issue = 1'b0;
      pushed   = 0;
      for (int c = 0; c < 4; c++) begin
         alu_valid  = 1'b1;
         alu_regdst = 2'b00;
         alu_reg    = 5'(20 + c);
         alu_data   = 32'hA0000000 + 32'(c);
         ll_valid   = (pushed < 3);
         ll_reg     = 5'(10 + pushed);
         ll_data    = 32'h00000100 + 32'(pushed);
         step(1'b0, no_exp, acc);
         if (acc) pushed++;
      end
      checkVal("ll_ready after 2 pushes", 32'(ll_ready), 32'd0);
      alu_valid = 1'b0;
      for (int c = 0; c < 10 && (pushed < 3 || llq.size() > 0); c++) begin
         ll_valid = (pushed < 3);
         ll_reg   = 5'(10 + pushed);
         ll_data  = 32'h00000100 + 32'(pushed);
         step(1'b0, no_exp, acc);
         if (acc) pushed++;
      end
      checkVal("queue all pushed", 32'(pushed), 32'd3);
      idle(1);

      $display("[TB] WAW on pending register");
      chk_ra       = 5'd0;
      chk_rb       = 5'd0;
      ll_issue     = 1'b1;
      ll_issue_reg = 5'd7;
      step(1'b0, no_exp, acc);
      ll_issue   = 1'b0;
      alu_valid  = 1'b1;
      alu_regdst = 2'b00;
      alu_reg    = 5'd7;
      alu_data   = 32'h00000077;
      step(1'b0, no_exp, acc);
      idle(10);
      checkVal("waw sticky", 32'(waw_err), 32'd1);
      ll_valid = 1'b1;
      ll_reg   = 5'd7;
      ll_data  = 32'h00000700;
      step(1'b0, no_exp, acc);
      idle(2);

      $display("[TB] reset mid-operation");
      alu_valid    = 1'b1;
      alu_reg      = 5'd20;
      alu_data     = 32'h0000CAFE;
      ll_issue     = 1'b1;
      ll_issue_reg = 5'd3;
      ll_valid     = 1'b1;
      ll_reg       = 5'd3;
      ll_data      = 32'h00000333;
      step(1'b0, no_exp, acc);
      ll_issue = 1'b0;
      ll_reg   = 5'd4;
      ll_data  = 32'h00000444;
      step(1'b0, no_exp, acc);
      checkVal("queue full before reset", 32'(ll_ready), 32'd0);
      alu_valid = 1'b0;
      ll_valid  = 1'b0;
      chk_ra    = 5'd3;
      reset     = 1'b1;
      #1;
      checkVal("async reset RegWrite", 32'(RegWrite), 32'd0);
      checkVal("async reset wreg", 32'(wreg), 32'd0);
      checkVal("async reset wdata", wdata, 32'd0);
      checkVal("async reset ll_ready", 32'(ll_ready), 32'd1);
      checkVal("async reset hazard", 32'(hazard), 32'd0);
      checkVal("async reset waw_err", 32'(waw_err), 32'd0);
      llq.delete();
      exp_q.delete();
      pending_m = '0;
      waw_m     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
